// File: rtl/rotation_controller.sv
// Rotation motor controller: requests a shortest-path delta, then ramps PWM duty toward a
// delta-dependent target, braking to zero before any direction reversal.
module rotation_controller #(
   parameter logic [11:0] TOLERANCE     = 12'd8,
   parameter logic [11:0] SLOW_ZONE     = 12'd256,
   parameter logic [7:0]  MAX_DUTY      = 8'd200,
   parameter logic [7:0]  MIN_DUTY      = 8'd40,
   parameter logic [7:0]  RAMP_STEP     = 8'd4,
   parameter int unsigned RAMP_DIV      = 16,
   parameter int unsigned UPDATE_PERIOD = 1000,
   parameter int unsigned CALC_TIMEOUT  = 32
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   output logic        enable_calc,
   input  logic        calc_updated,
   input  logic [11:0] delta_angle,
   input  logic        dir_shortest,
   output logic        pwm_enable,
   output logic        pwm_dir,
   output logic [7:0]  pwm_duty,
   output logic        rotation_busy,
   output logic        rotation_done,
   output logic        fault
);

   localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int UPD_W  = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
   localparam int WAIT_W = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
   localparam logic [UPD_W-1:0]  UPD_LAST  = UPD_W'(UPDATE_PERIOD - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CALC_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, REQ, WAIT_CALC, EVAL, RUN, BRAKE, DONE, FAULT
   } state_t;

   state_t             state, state_nxt;
   logic [7:0]         duty_nxt, target, target_nxt;
   logic               dir_nxt, en_nxt;
   logic [11:0]        delta_lat, delta_nxt;
   logic               dir_lat, dlat_nxt;
   logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
   logic [UPD_W-1:0]   upd_cnt, upd_nxt;
   logic [TICK_W-1:0]  tick_cnt, tick_nxt;

   // One saturating ramp step toward tgt; signed headroom avoids 8-bit wrap.
   function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
      logic signed [9:0] up;
      logic signed [9:0] dn;
      logic signed [9:0] tg;
      up = $signed({2'b00, cur}) + $signed({2'b00, RAMP_STEP});
      dn = $signed({2'b00, cur}) - $signed({2'b00, RAMP_STEP});
      tg = $signed({2'b00, tgt});
      if (cur < tgt)
         ramp_toward = (up > tg) ? tgt : up[7:0];
      else if (cur > tgt)
         ramp_toward = (dn < tg) ? tgt : dn[7:0];
      else
         ramp_toward = cur;
   endfunction

   always_comb begin
      state_nxt  = state;
      duty_nxt   = pwm_duty;
      dir_nxt    = pwm_dir;
      en_nxt     = pwm_enable;
      target_nxt = target;
      delta_nxt  = delta_lat;
      dlat_nxt   = dir_lat;
      wait_nxt   = wait_cnt;
      upd_nxt    = upd_cnt;
      tick_nxt   = tick_cnt;
      case (state)
         IDLE: begin
            duty_nxt = '0;
            en_nxt   = 1'b0;
            if (start) state_nxt = REQ;
         end
         REQ: begin
            wait_nxt  = '0;
            state_nxt = WAIT_CALC;
         end
         WAIT_CALC: begin
            if (calc_updated) begin
               delta_nxt = delta_angle;
               dlat_nxt  = dir_shortest;
               state_nxt = EVAL;
            end else if (wait_cnt == WAIT_LAST) begin
               duty_nxt  = '0;
               en_nxt    = 1'b0;
               state_nxt = FAULT;
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end
         EVAL: begin
            tick_nxt = '0;
            if (delta_lat <= TOLERANCE) begin
               duty_nxt  = '0;
               en_nxt    = 1'b0;
               state_nxt = DONE;
            end else if ((dir_lat != pwm_dir) && (pwm_duty != 8'd0)) begin
               // never reverse at speed: spin down first, then ask again
               target_nxt = '0;
               state_nxt  = BRAKE;
            end else begin
               dir_nxt    = dir_lat;
               en_nxt     = 1'b1;
               target_nxt = (delta_lat >= SLOW_ZONE) ? MAX_DUTY : MIN_DUTY;
               upd_nxt    = '0;
               state_nxt  = RUN;
            end
         end
         RUN: begin
            if (tick_cnt == TICK_LAST) begin
               tick_nxt = '0;
               duty_nxt = ramp_toward(pwm_duty, target);
            end else begin
               tick_nxt = tick_cnt + 1'b1;
            end
            if (upd_cnt == UPD_LAST) state_nxt = REQ;
            else                     upd_nxt   = upd_cnt + 1'b1;
         end
         BRAKE: begin
            if (pwm_duty == 8'd0) begin
               state_nxt = REQ;
            end else if (tick_cnt == TICK_LAST) begin
               tick_nxt = '0;
               duty_nxt = ramp_toward(pwm_duty, 8'd0);
            end else begin
               tick_nxt = tick_cnt + 1'b1;
            end
         end
         DONE: begin
            duty_nxt  = '0;
            en_nxt    = 1'b0;
            state_nxt = IDLE;
         end
         FAULT: begin
            duty_nxt = '0;
            en_nxt   = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt  = IDLE;
         duty_nxt   = '0;
         en_nxt     = 1'b0;
         target_nxt = '0;
         wait_nxt   = '0;
         upd_nxt    = '0;
         tick_nxt   = '0;
      end
   end

   // Status outputs are registered copies of the state being entered.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         pwm_duty      <= '0;
         pwm_dir       <= 1'b0;
         pwm_enable    <= 1'b0;
         target        <= '0;
         delta_lat     <= '0;
         dir_lat       <= 1'b0;
         wait_cnt      <= '0;
         upd_cnt       <= '0;
         tick_cnt      <= '0;
         enable_calc   <= 1'b0;
         rotation_busy <= 1'b0;
         rotation_done <= 1'b0;
         fault         <= 1'b0;
      end else begin
         state         <= state_nxt;
         pwm_duty      <= duty_nxt;
         pwm_dir       <= dir_nxt;
         pwm_enable    <= en_nxt;
         target        <= target_nxt;
         delta_lat     <= delta_nxt;
         dir_lat       <= dlat_nxt;
         wait_cnt      <= wait_nxt;
         upd_cnt       <= upd_nxt;
         tick_cnt      <= tick_nxt;
         enable_calc   <= (state_nxt == REQ);
         rotation_busy <= (state_nxt != IDLE) && (state_nxt != FAULT);
         rotation_done <= (state_nxt == DONE);
         fault         <= (state_nxt == FAULT);
      end
   end

endmodule

// File: tb/tb_rotation_controller.sv
// Bench for rotation_controller: randomized scenarios checked against closed-form ramp and
// timing expectations derived from the controller's rules.
module tb_rotation_controller;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        calc_updated = 1'b0;
   logic [11:0] delta_angle = '0;
   logic        dir_shortest = 1'b0;
   logic        enable_calc, pwm_enable, pwm_dir, rotation_busy, rotation_done, fault;
   logic [7:0]  pwm_duty;

   int n_checks = 0;
   int n_fail   = 0;

   rotation_controller dut (
      .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
      .enable_calc(enable_calc), .calc_updated(calc_updated),
      .delta_angle(delta_angle), .dir_shortest(dir_shortest),
      .pwm_enable(pwm_enable), .pwm_dir(pwm_dir), .pwm_duty(pwm_duty),
      .rotation_busy(rotation_busy), .rotation_done(rotation_done), .fault(fault)
   );

   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: duty after n cycles of ramping from d0 toward tgt, 4 per 16 cycles.
   function automatic int exp_ramp(input int d0, input int tgt, input int n);
      int moved;
      moved = 4 * (n / 16);
      if (d0 < tgt) return (d0 + moved > tgt) ? tgt : d0 + moved;
      else          return (d0 - moved < tgt) ? tgt : d0 - moved;
   endfunction

   function automatic int exp_target(input int delta);
      return (delta >= 256) ? 200 : 40;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // From REQ visible: wait dly extra cycles in WAIT_CALC, then deliver a result (EVAL visible after).
   task automatic give_calc(input int dly, input int delta, input bit dir);
      logic [31:0] dv;
      dv = delta;
      step();
      repeat (dly) step();
      delta_angle  = dv[11:0];
      dir_shortest = dir;
      calc_updated = 1'b1;
      step();
      calc_updated = 1'b0;
      delta_angle  = 12'($urandom);
      dir_shortest = 1'($urandom);
   endtask

   // Starting at the first visible RUN cycle, run ncyc cycles checking the ramp profile.
   task automatic run_cycles(input string tag, input int d0, input int tgt, input int ncyc);
      for (int n = 0; n < ncyc; n++) begin
         if ((n % 16 == 0) || (n % 16 == 15) || (n == ncyc - 1)) begin
            check({tag, "_duty"}, pwm_duty, exp_ramp(d0, tgt, n));
            check({tag, "_noreq"}, enable_calc, 0);
            check({tag, "_en"}, pwm_enable, 1);
         end
         step();
      end
   endtask

   initial begin
      int d;
      int r;
      bit dir;
      int deltas[12];

      // Reset state
      repeat (3) step();
      check("rst_duty", pwm_duty, 0);
      check("rst_en", pwm_enable, 0);
      check("rst_dir", pwm_dir, 0);
      check("rst_calc", enable_calc, 0);
      check("rst_busy", rotation_busy, 0);
      check("rst_done", rotation_done, 0);
      check("rst_fault", fault, 0);
      reset_n = 1'b1;
      step();

      // Already on target: done pulse, motor never enabled
      do_start();
      check("t1_req", enable_calc, 1);
      check("t1_busy", rotation_busy, 1);
      d = $urandom_range(0, 8);
      give_calc(7, d, 1'($urandom));
      check("t1_eval_en", pwm_enable, 0);
      check("t1_eval_done", rotation_done, 0);
      step();
      check("t1_done", rotation_done, 1);
      check("t1_done_en", pwm_enable, 0);
      check("t1_done_duty", pwm_duty, 0);
      step();
      check("t1_done_once", rotation_done, 0);
      check("t1_idle", rotation_busy, 0);
      check("t1_idle_en", pwm_enable, 0);

      // Randomized single requests, including tolerance and slow-zone edges
      deltas[0] = 8; deltas[1] = 9; deltas[2] = 255; deltas[3] = 256;
      for (int i = 4; i < 12; i++) deltas[i] = $urandom_range(0, 4095);
      for (int i = 0; i < 12; i++) begin
         dir = 1'($urandom);
         do_start();
         give_calc($urandom_range(0, 25), deltas[i], dir);
         step();
         if (deltas[i] <= 8) begin
            check("rnd_done", rotation_done, 1);
            check("rnd_done_en", pwm_enable, 0);
            step();
            check("rnd_idle", rotation_busy, 0);
         end else begin
            check("rnd_run_en", pwm_enable, 1);
            check("rnd_run_dir", pwm_dir, dir);
            check("rnd_run_duty0", pwm_duty, 0);
            r = $urandom_range(1, 999);
            repeat (r) step();
            check("rnd_duty", pwm_duty, exp_ramp(0, exp_target(deltas[i]), r));
            check("rnd_noreq", enable_calc, 0);
            abort = 1'b1;
            step();
            abort = 1'b0;
            check("rnd_abort_duty", pwm_duty, 0);
            check("rnd_abort_en", pwm_enable, 0);
            check("rnd_abort_busy", rotation_busy, 0);
         end
      end

      // Long delta, CW: ramp to cruise, recalc after 1000 RUN cycles
      do_start();
      give_calc($urandom_range(0, 30), $urandom_range(256, 4095), 1'b0);
      step();
      check("t2_dir", pwm_dir, 0);
      run_cycles("t2", 0, 200, 1000);
      check("t2_recalc", enable_calc, 1);
      check("t2_hold", pwm_duty, 200);
      check("t2_hold_en", pwm_enable, 1);

      // Short delta, same direction: ramp down to approach duty
      give_calc($urandom_range(0, 30), $urandom_range(9, 255), 1'b0);
      step();
      run_cycles("t3", 200, 40, 1000);
      check("t3_recalc", enable_calc, 1);
      check("t3_hold", pwm_duty, 40);

      // Back to cruise, then reversal request forces a brake
      give_calc($urandom_range(0, 30), $urandom_range(256, 4095), 1'b0);
      step();
      run_cycles("t4up", 40, 200, 1000);
      check("t4_at_cruise", pwm_duty, 200);
      give_calc($urandom_range(0, 30), $urandom_range(256, 4095), 1'b1);
      step();
      for (int m = 0; m <= 800; m++) begin
         if ((m % 16 == 0) || (m % 16 == 15)) begin
            check("t4_brake_duty", pwm_duty, exp_ramp(200, 0, m));
            check("t4_brake_dir", pwm_dir, 0);
            check("t4_brake_noreq", enable_calc, 0);
         end
         step();
      end
      check("t4_brake_req", enable_calc, 1);
      check("t4_brake_dir_end", pwm_dir, 0);
      check("t4_brake_duty_end", pwm_duty, 0);
      give_calc($urandom_range(0, 30), $urandom_range(256, 4095), 1'b1);
      step();
      check("t4_rev_dir", pwm_dir, 1);
      check("t4_rev_en", pwm_enable, 1);
      run_cycles("t4rev", 0, 200, 1000);
      check("t4_rev_req", enable_calc, 1);

      // Calc never answers: motor holds while waiting, then fault
      repeat (32) step();
      check("t5_wait_busy", rotation_busy, 1);
      check("t5_wait_fault", fault, 0);
      check("t5_wait_duty", pwm_duty, 200);
      check("t5_wait_en", pwm_enable, 1);
      step();
      check("t5_fault", fault, 1);
      check("t5_fault_duty", pwm_duty, 0);
      check("t5_fault_en", pwm_enable, 0);
      check("t5_fault_busy", rotation_busy, 0);
      start = 1'b1;
      calc_updated = 1'b1;
      step();
      start = 1'b0;
      calc_updated = 1'b0;
      check("t5_start_ign", enable_calc, 0);
      check("t5_fault_sticky", fault, 1);
      step();
      check("t5_fault_sticky2", fault, 1);
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      check("t5_abort_fault", fault, 0);
      check("t5_abort_busy", rotation_busy, 0);
      check("t5_abort_beats_start", enable_calc, 0);
      step();
      check("t5_idle_stays", rotation_busy, 0);

      // Abort mid-RUN at duty 120
      dir = 1'($urandom);
      do_start();
      give_calc($urandom_range(0, 30), $urandom_range(256, 4095), dir);
      step();
      repeat (480) step();
      check("t6_at120", pwm_duty, 120);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t6_abort_duty", pwm_duty, 0);
      check("t6_abort_en", pwm_enable, 0);
      check("t6_abort_busy", rotation_busy, 0);
      check("t6_abort_calc", enable_calc, 0);

      // Reset mid-RUN at duty 120
      do_start();
      give_calc($urandom_range(0, 30), $urandom_range(256, 4095), 1'b1);
      step();
      repeat (480) step();
      check("t6r_at120", pwm_duty, 120);
      check("t6r_dir", pwm_dir, 1);
      reset_n = 1'b0;
      step();
      check("t6r_duty", pwm_duty, 0);
      check("t6r_en", pwm_enable, 0);
      check("t6r_busy", rotation_busy, 0);
      check("t6r_dir0", pwm_dir, 0);
      reset_n = 1'b1;
      step();
      check("t6r_idle", rotation_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
